// File: rtl/h14rx_pkt_avi_info_frame_parser.sv
// Receive-side AVI InfoFrame parser: serial checksum over the captured packet,
// commit of PB1..PB13 into held fields, and frame-based staleness timeout.
// packet[23:0] = {HB2,HB1,HB0}; PBn lives at packet[24+8n +: 8] (n = 7*sub + byte).
module h14rx_pkt_avi_info_frame_parser #(
    parameter logic [7:0]  MinVersion    = 8'd2,
    parameter logic [15:0] TimeoutFrames = 16'd4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pkt_valid,
    input  logic [247:0] packet,
    output logic         pkt_ready,
    input  logic         frame_start,
    output logic         avi_valid,
    output logic         avi_update,
    output logic         avi_changed,
    output logic         avi_err,
    output logic         pkt_dropped,
    output logic [1:0]   video_format,
    output logic         afi_present,
    output logic [1:0]   bar_info,
    output logic [1:0]   scan_info,
    output logic [1:0]   colorimetry,
    output logic [1:0]   picture_aspect,
    output logic [3:0]   active_aspect,
    output logic         it_content,
    output logic [2:0]   ext_colorimetry,
    output logic [1:0]   rgb_quant,
    output logic [1:0]   nups,
    output logic [6:0]   vic,
    output logic [1:0]   ycc_quant,
    output logic [1:0]   content_type,
    output logic [3:0]   pixel_repetition,
    output logic [15:0]  bar_top_end,
    output logic [15:0]  bar_bottom_start,
    output logic [15:0]  bar_left_end,
    output logic [15:0]  bar_right_start
);
    typedef enum logic [1:0] {IDLE, SUM, CHECK} state_t;

    state_t        state, state_nxt;
    logic [223:0]  shadow;
    logic [7:0]    hb1;
    logic [7:0]    sum;
    logic [4:0]    len;
    logic [4:0]    idx;
    logic [4:0]    last_idx;
    logic [7:0]    pb_byte;
    logic [103:0]  held;
    logic [15:0]   frame_cnt;
    logic          accept;
    logic          good;
    logic          is_avi;

    assign is_avi   = (packet[7:0] == 8'h82);
    assign last_idx = (len > 5'd27) ? 5'd27 : len;
    assign pb_byte  = shadow[{idx, 3'b000} +: 8];
    assign good     = (state == CHECK) && (sum == 8'd0) && (hb1 >= MinVersion)
                      && (len >= 5'd13) && (len <= 5'd27);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pkt_ready = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid && is_avi) begin
                    accept    = 1'b1;
                    state_nxt = SUM;
                end
            end
            SUM:     if (idx == last_idx) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            hb1         <= '0;
            sum         <= '0;
            len         <= '0;
            idx         <= '0;
            held        <= '0;
            frame_cnt   <= '0;
            avi_valid   <= 1'b0;
            avi_update  <= 1'b0;
            avi_changed <= 1'b0;
            avi_err     <= 1'b0;
            pkt_dropped <= 1'b0;
        end else begin
            avi_update  <= 1'b0;
            avi_changed <= 1'b0;
            avi_err     <= 1'b0;
            pkt_dropped <= pkt_valid && is_avi && (state != IDLE);
            if (accept) begin
                shadow <= packet[247:24];
                hb1    <= packet[15:8];
                len    <= packet[20:16];
                sum    <= packet[7:0] + packet[15:8] + packet[23:16];
                idx    <= '0;
            end
            if (state == SUM) begin
                sum <= sum + pb_byte;
                idx <= idx + 5'd1;
            end
            // A good commit takes priority over a coincident frame_start.
            if (good) begin
                held        <= shadow[111:8];
                avi_update  <= 1'b1;
                avi_changed <= (held != shadow[111:8]);
                avi_valid   <= 1'b1;
                frame_cnt   <= '0;
            end else begin
                if (state == CHECK) avi_err <= 1'b1;
                if (frame_start && avi_valid && (frame_cnt != TimeoutFrames)) begin
                    frame_cnt <= frame_cnt + 16'd1;
                    if (frame_cnt + 16'd1 == TimeoutFrames) avi_valid <= 1'b0;
                end
            end
        end
    end

    assign video_format     = held[6:5];
    assign afi_present      = held[4];
    assign bar_info         = held[3:2];
    assign scan_info        = held[1:0];
    assign colorimetry      = held[15:14];
    assign picture_aspect   = held[13:12];
    assign active_aspect    = held[11:8];
    assign it_content       = held[23];
    assign ext_colorimetry  = held[22:20];
    assign rgb_quant        = held[19:18];
    assign nups             = held[17:16];
    assign vic              = held[30:24];
    assign ycc_quant        = held[39:38];
    assign content_type     = held[37:36];
    assign pixel_repetition = held[35:32];
    assign bar_top_end      = held[55:40];
    assign bar_bottom_start = held[71:56];
    assign bar_left_end     = held[87:72];
    assign bar_right_start  = held[103:88];
endmodule
